// File: rtl/hamming_codec_arbiter.sv
// hamming_codec_arbiter
//   Shares one external combinational Hamming(8,4) encoder/decoder pair
//   between two requesters. A round-robin arbiter grants one request at a
//   time. The granted operand is registered onto codec_din. The codec
//   outputs are captured one cycle later and returned on the owner's
//   response channel. Saturating counters track corrected and uncorrectable
//   decode results.
//
// Handshakes (both channels): a transfer happens on a rising clk edge where
//   valid and ready are both high for the same requester bit. The sender
//   holds valid and its payload until that edge. The receiver's ready may
//   depend combinationally on valid. After valid rises, the payload does
//   not change until the transfer completes.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req_valid/ready[1:0]  request channel, one bit per requester
//   req_mode[1:0]         per requester: 0 = encode, 1 = decode
//   req_data[15:0]        requester i operand on [8i+7:8i]
//   rsp_valid/ready[1:0]  response channel; only the owner's bit is used
//   rsp_data[7:0]         codeword (encode) or decoded data (decode)
//   rsp_status[4:0]       {syndrome, errors}; zero for encode
//   codec_din[7:0]        registered operand to the external codec
//   codec_enc/dec/syn/err codec results
//   busy                  high whenever the FSM is not IDLE
//   cnt_clr               clears both error counters
//   cnt_single/double     saturating error counters
//   state_dbg[1:0]        current FSM state (0 IDLE, 1 CALC, 2 RESP)

module hamming_codec_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [1:0]       req_mode,
  input  logic [15:0]      req_data,
  output logic [1:0]       req_ready,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [7:0]       rsp_data,
  output logic [4:0]       rsp_status,
  output logic [7:0]       codec_din,
  input  logic [7:0]       codec_enc,
  input  logic [7:0]       codec_dec,
  input  logic [2:0]       codec_syn,
  input  logic [1:0]       codec_err,
  output logic             busy,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_single,
  output logic [CNT_W-1:0] cnt_double,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic       last_q;   // requester granted most recently
  logic       owner_q;  // requester owning the current transaction
  logic       mode_q;   // 1 = decode
  logic       grant;
  logic       accept;
  logic       rsp_done;
  logic [7:0] sel_data;
  logic       inc_single;
  logic       inc_double;

  // Round-robin: the requester after last_q has priority. A lone valid
  // requester is granted regardless of priority.
  always_comb begin
    grant = 1'b0;
    if (last_q) begin
      grant = req_valid[0] ? 1'b0 : 1'b1;
    end else begin
      grant = req_valid[1] ? 1'b1 : 1'b0;
    end
  end

  assign sel_data = grant ? req_data[15:8] : req_data[7:0];
  assign accept   = (state_q == S_IDLE) && !rst && req_valid[grant];
  assign rsp_done = (state_q == S_RESP) && rsp_ready[owner_q];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_CALC;
      S_CALC:  state_d = S_RESP;
      S_RESP:  if (rsp_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic. req_ready is masked during reset so that no request
  // appears accepted on a cycle where the FSM is being cleared.
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    case (state_q)
      S_IDLE: if (!rst && req_valid[grant]) req_ready[grant] = 1'b1;
      S_RESP: rsp_valid[owner_q] = 1'b1;
      default: ;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

  // Transaction registers. The operand is captured at accept time, so later
  // changes on req_data/req_mode do not affect the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      mode_q     <= 1'b0;
      codec_din  <= 8'h00;
      rsp_data   <= 8'h00;
      rsp_status <= 5'h00;
    end else begin
      if (accept) begin
        owner_q <= grant;
        mode_q  <= req_mode[grant];
        // Encode takes only the low nibble; the upper nibble is forced to
        // zero so the codec sees a clean operand.
        codec_din <= req_mode[grant] ? sel_data : {4'b0000, sel_data[3:0]};
      end
      if (state_q == S_CALC) begin
        if (mode_q) begin
          rsp_data   <= codec_dec;
          rsp_status <= {codec_syn, codec_err};
        end else begin
          rsp_data   <= codec_enc;
          rsp_status <= 5'h00;
        end
      end
      if (rsp_done) begin
        last_q <= owner_q;
      end
    end
  end

  // Error counters. A clear in the same cycle as an increment wins.
  assign inc_single = (state_q == S_CALC) && mode_q && (codec_err == 2'b01);
  assign inc_double = (state_q == S_CALC) && mode_q && codec_err[1];

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cnt_single <= '0;
      cnt_double <= '0;
    end else begin
      if (inc_single && (cnt_single != {CNT_W{1'b1}})) begin
        cnt_single <= cnt_single + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (inc_double && (cnt_double != {CNT_W{1'b1}})) begin
        cnt_double <= cnt_double + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_hamming_codec_arbiter.sv
// Bench for hamming_codec_arbiter. It provides a behavioural Hamming(8,4)
// codec on the codec_* ports and drives requests from directed steps.
// Expected responses are queued at request time and popped when a response
// appears. Inputs change on the falling edge and outputs are sampled there.

module tb_hamming_codec_arbiter;

  localparam int CNT_W = 2;
  localparam int W     = 15;  // {rsp_valid[1:0], rsp_data[7:0], rsp_status[4:0]}

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_mode;
  logic [15:0]      req_data;
  logic [1:0]       req_ready;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [7:0]       rsp_data;
  logic [4:0]       rsp_status;
  logic [7:0]       codec_din;
  logic [7:0]       codec_enc;
  logic [7:0]       codec_dec;
  logic [2:0]       codec_syn;
  logic [1:0]       codec_err;
  logic             busy;
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt_single;
  logic [CNT_W-1:0] cnt_double;
  logic [1:0]       state_dbg;

  logic [W-1:0]     exp_q[$];
  int               n_cmp = 0;
  int               n_err = 0;
  logic             exp_last;
  logic [CNT_W-1:0] exp_single;
  logic [CNT_W-1:0] exp_double;

  hamming_codec_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_mode(req_mode), .req_data(req_data),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_status(rsp_status),
    .codec_din(codec_din), .codec_enc(codec_enc), .codec_dec(codec_dec),
    .codec_syn(codec_syn), .codec_err(codec_err),
    .busy(busy), .cnt_clr(cnt_clr),
    .cnt_single(cnt_single), .cnt_double(cnt_double),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference codec ----------------
  // Codeword layout: [0] overall parity, [1] p1, [2] p2, [3] d0,
  // [4] p3, [5] d1, [6] d2, [7] d3.
  function automatic logic [7:0] ham_enc(input logic [3:0] d);
    logic [7:0] c;
    c    = 8'h00;
    c[3] = d[0];
    c[5] = d[1];
    c[6] = d[2];
    c[7] = d[3];
    c[1] = d[0] ^ d[1] ^ d[3];
    c[2] = d[0] ^ d[2] ^ d[3];
    c[4] = d[1] ^ d[2] ^ d[3];
    c[0] = ^c[7:1];
    return c;
  endfunction

  // Returns {data[7:0], syndrome[2:0], errors[1:0]}.
  function automatic logic [12:0] ham_dec(input logic [7:0] c);
    logic [2:0] s;
    logic       ov;
    logic [7:0] f;
    logic [1:0] e;
    s  = {c[4] ^ c[5] ^ c[6] ^ c[7], c[2] ^ c[3] ^ c[6] ^ c[7], c[1] ^ c[3] ^ c[5] ^ c[7]};
    ov = ^c;
    f  = c;
    e  = 2'b00;
    if (ov) begin
      e    = 2'b01;
      f[s] = ~f[s];
    end else if (s != 3'd0) begin
      e = 2'b10;
    end
    return {4'b0000, f[7], f[6], f[5], f[3], s, e};
  endfunction

  always_comb begin
    {codec_dec, codec_syn, codec_err} = ham_dec(codec_din);
    codec_enc = ham_enc(codec_din[3:0]);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One full transaction, entered and left on a falling edge.
  //   mask     req_valid pattern to present
  //   hold     cycles the owner's rsp_ready is held low (non-owner toggles)
  //   keep     leave req_valid asserted after the handshake
  //   clr_calc pulse cnt_clr during the CALC cycle
  //   abort    apply a one-cycle reset in RESP instead of consuming
  task automatic txn(input logic [1:0] mask, input logic [1:0] mode, input logic [15:0] data,
                     input int hold, input bit keep, input bit clr_calc, input bit abort);
    int               t;
    logic             g;
    logic             m;
    logic [1:0]       oh;
    logic [7:0]       op;
    logic [7:0]       din;
    logic [12:0]      dr;
    logic [W-1:0]     exp_w;
    logic [CNT_W-1:0] old_s;
    logic [CNT_W-1:0] old_d;
    req_valid = mask;
    req_mode  = mode;
    req_data  = data;
    g  = exp_last ? (mask[0] ? 1'b0 : 1'b1) : (mask[1] ? 1'b1 : 1'b0);
    oh = g ? 2'b10 : 2'b01;
    #1;
    t = 0;
    while (req_ready == 2'b00 && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("req_ready_grant", 32'(req_ready), 32'(oh));
    if (req_ready == 2'b00) begin
      req_valid = 2'b00;
      return;
    end
    op  = g ? data[15:8] : data[7:0];
    m   = mode[g];
    din = m ? op : {4'b0000, op[3:0]};
    old_s = exp_single;
    old_d = exp_double;
    if (m) begin
      dr = ham_dec(din);
      exp_w = {oh, dr[12:5], dr[4:0]};
      if (dr[1:0] == 2'b01 && exp_single != '1) exp_single++;
      if (dr[1] && exp_double != '1) exp_double++;
    end else begin
      exp_w = {oh, ham_enc(op[3:0]), 5'b00000};
    end
    if (clr_calc) begin
      exp_single = '0;
      exp_double = '0;
    end
    exp_q.push_back(exp_w);

    // CALC cycle: operand registered, request data free to change.
    @(negedge clk);
    if (!keep) req_valid = 2'b00;
    req_data = 16'($urandom);
    req_mode = 2'($urandom_range(0, 3));
    check("calc_codec_din", 32'(codec_din), 32'(din));
    check("calc_state", 32'(state_dbg), 32'd1);
    check("calc_req_ready", 32'(req_ready), 32'd0);
    check("calc_rsp_valid", 32'(rsp_valid), 32'd0);
    check("calc_cnt", 32'({cnt_single, cnt_double}), 32'({old_s, old_d}));
    if (clr_calc) cnt_clr = 1'b1;

    // RESP: response must be visible two edges after the accept edge.
    @(negedge clk);
    cnt_clr = 1'b0;
    check("rsp_cnt", 32'({cnt_single, cnt_double}), 32'({exp_single, exp_double}));
    check("rsp_latency", 32'(rsp_valid), 32'(oh));
    t = 0;
    while (rsp_valid == 2'b00 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    exp_w = exp_q.pop_front();
    check("rsp_payload", 32'({rsp_valid, rsp_data, rsp_status}), 32'(exp_w));

    if (abort) begin
      req_valid = 2'b11;
      rst = 1'b1;
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      req_valid = 2'b00;
      exp_last   = 1'b1;
      exp_single = '0;
      exp_double = '0;
      check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      check("abort_state", 32'({state_dbg, busy}), 32'd0);
      check("abort_outputs", 32'({rsp_data, rsp_status, codec_din}), 32'd0);
      check("abort_cnt", 32'({cnt_single, cnt_double}), 32'd0);
      return;
    end

    // Backpressure: owner ready low, non-owner ready toggling.
    for (int i = 0; i < hold; i++) begin
      rsp_ready = i[0] ? 2'b00 : ~oh;
      @(negedge clk);
      check("hold_payload", 32'({rsp_valid, rsp_data, rsp_status}), 32'(exp_w));
      check("hold_busy_ready", 32'({busy, req_ready}), 32'b100);
    end

    rsp_ready = oh;
    @(negedge clk);
    rsp_ready = 2'b00;
    exp_last  = g;
    check("done_idle", 32'({state_dbg, rsp_valid}), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] cw;
    rst        = 1'b1;
    req_valid  = 2'b11;
    req_mode   = 2'b00;
    req_data   = 16'h0000;
    rsp_ready  = 2'b00;
    cnt_clr    = 1'b0;
    exp_last   = 1'b1;
    exp_single = '0;
    exp_double = '0;
    repeat (2) @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_rsp", 32'({rsp_valid, rsp_data, rsp_status}), 32'd0);
    check("reset_misc", 32'({codec_din, busy, state_dbg}), 32'd0);
    check("reset_cnt", 32'({cnt_single, cnt_double}), 32'd0);
    req_valid = 2'b00;
    rst = 1'b0;
    @(negedge clk);

    // Encode from requester 0; upper nibble of F5 must be dropped.
    txn(2'b01, 2'b00, 16'h00F5, 0, 1'b0, 1'b0, 1'b0);

    // Decode with a single flipped bit from requester 1.
    cw = ham_enc(4'hB) ^ 8'h08;
    txn(2'b10, 2'b10, {cw, 8'h00}, 0, 1'b0, 1'b0, 1'b0);

    // Fairness: both requesters valid throughout, grants alternate 0,1,0,1.
    txn(2'b11, 2'b00, 16'h3C07, 1, 1'b1, 1'b0, 1'b0);
    txn(2'b11, 2'b10, {ham_enc(4'h6), 8'h11}, 1, 1'b1, 1'b0, 1'b0);
    txn(2'b11, 2'b01, {8'h22, ham_enc(4'h9) ^ 8'h40}, 1, 1'b1, 1'b0, 1'b0);
    txn(2'b11, 2'b00, 16'hAE13, 1, 1'b1, 1'b0, 1'b0);
    req_valid = 2'b00;

    // Backpressure on a clean decode.
    txn(2'b01, 2'b01, {8'h00, ham_enc(4'hD)}, 5, 1'b0, 1'b0, 1'b0);

    // Five double-error decodes saturate cnt_double, then a sixth with clear.
    for (int i = 0; i < 5; i++) begin
      cw = ham_enc(4'(i + 3)) ^ 8'h06;
      txn(2'b10, 2'b10, {cw, 8'h00}, 0, 1'b0, 1'b0, 1'b0);
    end
    check("sat_cnt_double", 32'(cnt_double), 32'd3);
    cw = ham_enc(4'hF) ^ 8'h81;
    txn(2'b10, 2'b10, {cw, 8'h00}, 0, 1'b0, 1'b1, 1'b0);

    // Reset in RESP after a counted single-error decode.
    cw = ham_enc(4'h2) ^ 8'h20;
    txn(2'b01, 2'b01, {8'h00, cw}, 0, 1'b0, 1'b0, 1'b1);

    // Requester 0 must win first after reset.
    txn(2'b11, 2'b00, 16'h0A05, 0, 1'b0, 1'b0, 1'b0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
